// File: rtl/fanctrl_pkg.sv
// Shared fan-controller definitions: loader FSM encoding, frame constants, coefficient slots.
package fanctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    CHECK   = 2'd2,
    PENDING = 2'd3
  } state_e;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;
  localparam int         NUM_COEFFS          = 5;

  localparam int A0 = 0;
  localparam int A1 = 1;
  localparam int B0 = 2;
  localparam int B1 = 3;
  localparam int B2 = 4;

endpackage

// File: rtl/pid_coeff_timeout.sv
// Inter-byte idle counter; expired_o flags the edge on which the idle count reaches TIMEOUT_CYCLES.
module pid_coeff_timeout #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Combinational so the FSM leaves the frame on exactly the TIMEOUT_CYCLES-th idle edge.
  assign expired_o = en_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pid_coeff_loader.sv
// Byte-serial PID coefficient loader with atomic commit on pid_tick_i.
// Optional XOR checksum byte compiled in with `define PID_COEFF_CHECKSUM_EN.
module pid_coeff_loader
  import fanctrl_pkg::*;
#(
  parameter int         REG_BITWIDTH   = 32,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] HEADER_BYTE    = HEADER_BYTE_DEFAULT
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           byte_valid_i,
  input  logic [7:0]                     byte_data_i,
  output logic                           byte_ready_o,
  input  logic                           pid_tick_i,
  output logic signed [REG_BITWIDTH-1:0] a0_o,
  output logic signed [REG_BITWIDTH-1:0] a1_o,
  output logic signed [REG_BITWIDTH-1:0] b0_o,
  output logic signed [REG_BITWIDTH-1:0] b1_o,
  output logic signed [REG_BITWIDTH-1:0] b2_o,
  output logic                           commit_o,
  output logic                           pending_o,
  output logic                           error_o
);

  localparam int BPW    = REG_BITWIDTH / 8;
  localparam int NBYTES = NUM_COEFFS * BPW;
  localparam int IDX_W  = $clog2(NBYTES);

  state_e                                    state_q;
  logic [IDX_W-1:0]                          idx_q;
  logic [NUM_COEFFS-1:0][REG_BITWIDTH-1:0]   shadow_q;
  logic [NUM_COEFFS-1:0][REG_BITWIDTH-1:0]   coef_q;
  logic                                      commit_q;
  logic                                      error_q;
`ifdef PID_COEFF_CHECKSUM_EN
  logic [7:0]                                xor_q;
`endif

  logic accept, in_frame, last_byte, tmo;

  assign byte_ready_o = (state_q != PENDING);
  assign accept       = byte_valid_i && byte_ready_o;
  assign in_frame     = (state_q == LOAD) || (state_q == CHECK);
  assign last_byte    = (idx_q == IDX_W'(NBYTES - 1));

  pid_coeff_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (accept || !in_frame),
    .en_i      (in_frame),
    .expired_o (tmo)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      coef_q   <= '0;
      commit_q <= 1'b0;
      error_q  <= 1'b0;
`ifdef PID_COEFF_CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      commit_q <= 1'b0;
      error_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept && byte_data_i == HEADER_BYTE) begin
            state_q <= LOAD;
            idx_q   <= '0;
`ifdef PID_COEFF_CHECKSUM_EN
            xor_q   <= '0;
`endif
          end
        end
        LOAD: begin
          if (tmo) begin
            error_q <= 1'b1;
            state_q <= IDLE;
          end else if (accept) begin
            // Flat byte index maps straight onto word/byte since words arrive a0..b2, LSB first.
            for (int i = 0; i < NBYTES; i++)
              if (idx_q == IDX_W'(i)) shadow_q[i / BPW][(i % BPW) * 8 +: 8] <= byte_data_i;
`ifdef PID_COEFF_CHECKSUM_EN
            xor_q <= xor_q ^ byte_data_i;
`endif
            if (last_byte) begin
              idx_q <= '0;
`ifdef PID_COEFF_CHECKSUM_EN
              state_q <= CHECK;
`else
              state_q <= PENDING;
`endif
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
`ifdef PID_COEFF_CHECKSUM_EN
        CHECK: begin
          if (tmo) begin
            error_q <= 1'b1;
            state_q <= IDLE;
          end else if (accept) begin
            if (byte_data_i == xor_q) begin
              state_q <= PENDING;
            end else begin
              error_q <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
`endif
        PENDING: begin
          if (pid_tick_i) begin
            coef_q   <= shadow_q;
            commit_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a0_o      = coef_q[A0];
  assign a1_o      = coef_q[A1];
  assign b0_o      = coef_q[B0];
  assign b1_o      = coef_q[B1];
  assign b2_o      = coef_q[B2];
  assign commit_o  = commit_q;
  assign error_o   = error_q;
  assign pending_o = (state_q == PENDING);

endmodule

// File: tb/tb_pid_coeff_loader.sv
// Directed bench for pid_coeff_loader; checksum cases build with PID_COEFF_CHECKSUM_EN.
module tb_pid_coeff_loader;

  localparam int W = 32;
  localparam int T = 1000;
`ifdef PID_COEFF_CHECKSUM_EN
  localparam int FLEN = 22;
`else
  localparam int FLEN = 21;
`endif

  logic clk = 1'b0;
  logic rst, valid, tick;
  logic [7:0] data;
  logic ready, commit, pending, error;
  logic signed [W-1:0] a0, a1, b0, b1, b2;

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] frame [FLEN];

  always #5 clk = ~clk;

  pid_coeff_loader #(.REG_BITWIDTH(W), .TIMEOUT_CYCLES(T), .HEADER_BYTE(8'hA5)) dut (
    .clk_i(clk), .rst_i(rst), .byte_valid_i(valid), .byte_data_i(data),
    .byte_ready_o(ready), .pid_tick_i(tick),
    .a0_o(a0), .a1_o(a1), .b0_o(b0), .b1_o(b1), .b2_o(b2),
    .commit_o(commit), .pending_o(pending), .error_o(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_coefs(input string tag, input logic [31:0] e0, e1, e2, e3, e4);
    chk({tag, ".a0"}, a0, e0);
    chk({tag, ".a1"}, a1, e1);
    chk({tag, ".b0"}, b0, e2);
    chk({tag, ".b1"}, b1, e3);
    chk({tag, ".b2"}, b2, e4);
  endtask

  task automatic build(input logic [31:0] w0, w1, w2, w3, w4);
    logic [31:0] w [5];
    logic [7:0]  x;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4;
    x = 8'h00;
    frame[0] = 8'hA5;
    for (int k = 0; k < 5; k++)
      for (int b = 0; b < 4; b++) begin
        frame[1 + k*4 + b] = w[k][b*8 +: 8];
        x ^= w[k][b*8 +: 8];
      end
`ifdef PID_COEFF_CHECKSUM_EN
    frame[21] = x;
`endif
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      valid = 1'b1;
      data  = frame[i];
      @(posedge clk); #1;
    end
    valid = 1'b0;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  initial begin
    logic [7:0] junk [3];
    junk[0] = 8'h00; junk[1] = 8'hFF; junk[2] = 8'h5A;
    rst = 1'b1; valid = 1'b0; tick = 1'b0; data = 8'h00;
    repeat (2) @(posedge clk); #1;

    // reset state
    chk("rst.ready", ready, 1);
    chk("rst.pending", pending, 0);
    chk("rst.commit", commit, 0);
    chk("rst.error", error, 0);
    chk_coefs("rst", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // junk in IDLE dropped, tick in IDLE ignored
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; data = junk[i];
      @(posedge clk); #1;
      chk("junk.error", error, 0);
      chk("junk.ready", ready, 1);
      chk("junk.pending", pending, 0);
    end
    valid = 1'b0;
    tick_once();
    chk("idle_tick.commit", commit, 0);
    chk_coefs("idle_tick", 0, 0, 0, 0, 0);

    // happy path
    build(32'h00000001, 32'hFFFFFFFE, 32'h10, 32'h20, 32'h30);
    send(FLEN);
    chk("hp.pending", pending, 1);
    chk("hp.ready", ready, 0);
    chk("hp.error", error, 0);
    chk_coefs("hp.before", 0, 0, 0, 0, 0);
    tick_once();
    chk("hp.commit", commit, 1);
    chk("hp.pending_drop", pending, 0);
    chk("hp.ready_back", ready, 1);
    chk_coefs("hp.after", 32'h1, 32'hFFFFFFFE, 32'h10, 32'h20, 32'h30);
    @(posedge clk); #1;
    chk("hp.commit_1cyc", commit, 0);

    // atomicity, header value as data, bytes offered while pending
    build(32'h12A5A534, 32'hA5A5A5A5, 32'h80000000, 32'h7FFFFFFF, 32'h0);
    send(FLEN);
    valid = 1'b1; data = 8'hA5;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      chk("atom.ready", ready, 0);
      chk("atom.pending", pending, 1);
      chk("atom.a1_old", a1, 32'hFFFFFFFE);
    end
    valid = 1'b0;
    tick_once();
    chk("atom.commit", commit, 1);
    chk_coefs("atom", 32'h12A5A534, 32'hA5A5A5A5, 32'h80000000, 32'h7FFFFFFF, 32'h0);
    @(posedge clk); #1;
    chk("atom.idle_pending", pending, 0);
    chk("atom.idle_error", error, 0);

    // timeout after header + 7 data bytes
    build(32'hDEADBEEF, 32'h1, 32'h2, 32'h3, 32'h4);
    send(8);
    repeat (T - 1) @(posedge clk);
    #1;
    chk("tmo.early", error, 0);
    @(posedge clk); #1;
    chk("tmo.fire", error, 1);
    chk("tmo.ready", ready, 1);
    @(posedge clk); #1;
    chk("tmo.pulse1", error, 0);
    tick_once();
    chk("tmo.no_commit", commit, 0);
    chk_coefs("tmo.kept", 32'h12A5A534, 32'hA5A5A5A5, 32'h80000000, 32'h7FFFFFFF, 32'h0);
    build(32'hCAFEF00D, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00);
    send(FLEN);
    chk("tmo2.pending", pending, 1);
    tick_once();
    chk("tmo2.commit", commit, 1);
    chk_coefs("tmo2", 32'hCAFEF00D, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00);

    // reset mid-frame
    build(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    send(11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstm.ready", ready, 1);
    chk("rstm.pending", pending, 0);
    chk("rstm.error", error, 0);
    chk_coefs("rstm", 0, 0, 0, 0, 0);
    build(32'h00000100, 32'h00020000, 32'h03000000, 32'h00000004, 32'h00000000);
    send(FLEN);
    chk("rstm2.pending", pending, 1);
    tick_once();
    chk("rstm2.commit", commit, 1);
    chk_coefs("rstm2", 32'h100, 32'h20000, 32'h3000000, 32'h4, 32'h0);

`ifdef PID_COEFF_CHECKSUM_EN
    // good checksum commits, corrupted checksum errors
    build(32'h01020304, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("cks.byte", frame[21], 8'h04);
    send(FLEN);
    chk("cks.pending", pending, 1);
    tick_once();
    chk("cks.commit", commit, 1);
    chk_coefs("cks", 32'h01020304, 0, 0, 0, 0);
    build(32'h0A0B0C0D, 32'h1, 32'h1, 32'h1, 32'h1);
    frame[21] = frame[21] ^ 8'h01;
    send(FLEN);
    chk("cksbad.error", error, 1);
    chk("cksbad.pending", pending, 0);
    tick_once();
    chk("cksbad.error_1cyc", error, 0);
    chk("cksbad.commit", commit, 0);
    chk_coefs("cksbad", 32'h01020304, 0, 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pid_coeff_loader.md
# pid_coeff_loader

Byte-serial loader and commit scheduler for the five PID coefficients (a0, a1, b0, b1, b2) consumed by the fan controller's PID core. It sits between the host byte interface (UART/SPI front end) and the PID coefficient inputs. It assembles a framed coefficient set into shadow registers and optionally checks it. It then commits all five words atomically on a PID tick, so a PID computation never sees a mixed old/new coefficient set.

## Interface
- REG_BITWIDTH, 32, coefficient width; must be a multiple of 8.
- TIMEOUT_CYCLES, 1000, maximum idle clk_i cycles between accepted bytes inside a frame.
- HEADER_BYTE, 8'hA5, frame start marker.

- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- byte_valid_i  in  1  host byte present.
- byte_data_i  in  8  host byte.
- byte_ready_o  out  1  loader accepts a byte this cycle; reset 1.
- pid_tick_i  in  1  PID clock-enable strobe (one cycle per PID period).
- a0_o, a1_o, b0_o, b1_o, b2_o  out  REG_BITWIDTH each, signed, active coefficients; reset 0.
- commit_o  out  1  one-cycle pulse when a new set becomes active; reset 0.
- pending_o  out  1  complete set waiting for pid_tick_i; reset 0.
- error_o  out  1  one-cycle pulse on a frame error; reset 0.

## Operation
- Byte accepted iff byte_valid_i && byte_ready_o at a rising clk_i.
- Frame format: HEADER_BYTE, then 5 × (REG_BITWIDTH/8) data bytes in the order a0, a1, b0, b1, b2, each little-endian. With the checksum feature enabled, one checksum byte follows.
- States:
  - IDLE: ready=1. A byte equal to HEADER_BYTE → LOAD. Any other byte is dropped silently.
  - LOAD: ready=1. Each byte is written into shadow[word][byte], and the byte index increments. After the last data byte → CHECK if enabled, else PENDING.
  - CHECK: ready=1. The next byte is compared with the running XOR of all data bytes. Match → PENDING. Mismatch → error_o pulse, → IDLE, shadow discarded.
  - PENDING: ready=0, pending_o=1. When pid_tick_i=1, all active outputs load from shadow on that edge → IDLE; commit_o pulses the following cycle.
- Timeout: in LOAD/CHECK, a counter resets on every accepted byte and increments otherwise. Reaching TIMEOUT_CYCLES → error_o pulse, → IDLE, active coefficients unchanged.
- pid_tick_i outside PENDING is ignored. Active outputs change only on a commit edge or reset.
- A HEADER_BYTE value received inside LOAD is data, not a restart.
- rst_i mid-frame or in PENDING: state → IDLE, shadow/index/timer/XOR cleared, all outputs to reset values.

## Timing
- Byte acceptance is zero-latency: ready is combinational from state only, never from byte_valid_i.
- The active coefficient update is visible in the cycle after the edge where pid_tick_i=1 is sampled in PENDING. commit_o is high in that same cycle, for exactly 1 cycle.
- Minimum frame-to-commit time is 21 bytes (22 with checksum) at 1 byte/cycle, plus the wait for pid_tick_i.
- error_o is asserted the cycle after the offending byte or timeout edge, for 1 cycle.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last accepted byte.

## Configuration
- PID_COEFF_CHECKSUM_EN defined: the CHECK state and XOR accumulator are compiled in, and the frame is 22 bytes.
- PID_COEFF_CHECKSUM_EN undefined: no CHECK state and no accumulator. The frame is 21 bytes, and LOAD goes directly to PENDING after the final data byte.

## Structure
- Shared package fanctrl_pkg holds:
  - the state encoding (IDLE, LOAD, CHECK, PENDING);
  - HEADER_BYTE default;
  - NUM_COEFFS = 5;
  - coefficient index constants A0=0, A1=1, B0=2, B1=3, B2=4.
- One sub-module, pid_coeff_timeout, holds the inter-byte timeout counter with clear/enable inputs and an expiry output.
- Shadow registers, byte index and FSM live in the top module.

## Test plan
- Happy path (checksum off): send A5, then a0=0x00000001, a1=0xFFFFFFFE, b0=0x10, b1=0x20, b2=0x30 little-endian, then one pid_tick_i. Outputs update the cycle after the tick, commit_o pulses once, pending_o drops.
- Atomicity: complete a frame, then hold pid_tick_i low 500 cycles. Outputs keep old values and byte_ready_o stays 0 throughout; byte_valid_i bytes during this window are not accepted.
- Timeout: send A5 plus 7 bytes, then stall 1000 cycles. error_o pulses once, state returns to IDLE, outputs unchanged. A new full frame then commits correctly.
- Checksum (PID_COEFF_CHECKSUM_EN): a frame with correct XOR commits. The same frame with its checksum byte XOR 0x01 gives an error_o pulse and no commit even when pid_tick_i fires.
- Reset mid-frame: assert rst_i after 10 data bytes. All outputs become 0, byte_ready_o=1. A fresh frame then commits without residue from the aborted one.
- Junk in IDLE: bytes 0x00, 0xFF, 0x5A before A5 are dropped silently with no error_o, and the following frame commits normally.
